cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Arbitrates the single off-core memory port between ICache line refill (read-only) and DCache line refill or write-back.
- Sits between the two cache controllers and the memory bus wrapper.
- Sequences one whole burst transaction at a time (address, data beats, write response) with round-robin fairness on contention.
- Gives the IFU deterministic refill service while the DCache is writing back dirty lines.

Parameters:
ADDR_WD, 32, address width
DATA_WD, 64, data beat width
BURST_LEN, 4, beats per cache line (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  ICache refill request; level, held until i_rlast
i_addr  in  ADDR_WD  ICache miss address
i_rvalid  out  1  refill beat valid to ICache
i_rdata  out  DATA_WD  refill beat data
i_rlast  out  1  final refill beat
d_req  in  1  DCache request; level, held until d_done
d_we  in  1  1 = write-back, 0 = refill
d_addr  in  ADDR_WD  DCache line address
d_wdata  in  DATA_WD  current write-back beat
d_wready  out  1  write beat consumed this cycle
d_rvalid  out  1  refill beat valid to DCache
d_rdata  out  DATA_WD  refill beat data
d_done  out  1  one-cycle pulse at transaction end (read last beat or write response)
mem_req  out  1  address phase valid
mem_we  out  1  address phase direction
mem_addr  out  ADDR_WD  line-aligned burst start address
mem_ready  in  1  address accepted
mem_wvalid  out  1  write beat valid
mem_wdata  out  DATA_WD  write beat data
mem_wlast  out  1  final write beat
mem_wready  in  1  write beat accepted
mem_rvalid  in  1  read beat valid
mem_rdata  in  DATA_WD  read beat data
mem_bvalid  in  1  write response
busy  out  1  state != IDLE

Behaviour:
- Reset: clk rising edge with reset=1. Outcome: state=IDLE, beat counter=0, owner=I, rr_last_d=0, latched addr/we=0. All outputs are 0 while in IDLE.
- Reset mid-burst: abandons the transaction immediately; no completion pulse is produced.
- FSM states: IDLE, ADDR, RDATA, WDATA, WRESP.
- IDLE arbitration (requests sampled only in IDLE):
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant D if rr_last_d=0, else I.
  - On grant: latch owner, address and we (we forced 0 for I), set rr_last_d = (owner==D), next state ADDR.
- ADDR:
  - mem_req=1; mem_we=latched we.
  - mem_addr = latched addr with low log2(BURST_LEN*DATA_WD/8) bits zeroed.
  - Held stable until mem_ready. On mem_ready: we ? WDATA : RDATA; counter cleared.
- RDATA:
  - mem_rdata is routed combinationally to the owner's rdata; owner's rvalid = mem_rvalid. Non-owner rvalid stays 0.
  - Counter increments on each mem_rvalid.
  - Beat with counter==BURST_LEN-1: i_rlast=1 (owner I) or d_done=1 (owner D) in the same cycle, next state IDLE.
- WDATA:
  - mem_wvalid=1, mem_wdata=d_wdata (combinational).
  - d_wready=mem_wready; counter increments on mem_wready.
  - mem_wlast=1 when counter==BURST_LEN-1. Accepted last beat leads to WRESP.
- WRESP: wait for mem_bvalid; on it pulse d_done, next state IDLE.
- Latency: request seen in IDLE at cycle T gives mem_req at T+1. Minimum read transaction is 1 + 1 + BURST_LEN cycles.
- Back-to-back: after completion the arbiter spends one cycle in IDLE. A requester must drop req in the completion cycle, otherwise it is re-granted.
- Counter width is log2(BURST_LEN) and wraps to 0 after the last beat.
- mem_rvalid outside RDATA and mem_bvalid outside WRESP are ignored.
- Address/we changes on the requester side after grant are ignored until the next IDLE.

Test Plan:
- Lone I refill: i_req, i_addr=0x8000_0014, mem_ready at +2, 4 rvalid beats 0xA0..0xA3. Expect mem_addr=0x8000_0000, mem_we=0, i_rvalid x4 with same data, i_rlast on 0xA3, d_rvalid=0 throughout.
- Simultaneous i_req and d_req (refill) after reset: D granted first, I granted in the next IDLE; a third contention goes to D again.
- D write-back with mem_wready toggling 1,0,1,1,0,1: exactly 4 d_wready pulses, mem_wlast only on beat 4, WRESP held 3 cycles until mem_bvalid, d_done one cycle.
- mem_ready delayed 5 cycles: mem_req and mem_addr stable all 5 cycles, no data beats forwarded early.
- Reset asserted during beat 2 of an I refill: next cycle all outputs 0 and state IDLE; a fresh d_req is then granted (rr_last_d=0).
- Stray mem_rvalid and mem_bvalid in IDLE: no output pulses, state unchanged.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Memory port arbiter: shares one burst memory port between ICache refills and
// DCache refills/write-backs, one whole line transaction at a time, with
// round-robin selection when both caches ask in the same cycle.
module cache_mem_arbiter #(
   parameter int unsigned ADDR_WD   = 32,
   parameter int unsigned DATA_WD   = 64,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic               clk,
   input  logic               reset,
   // ICache refill side
   input  logic               i_req,
   input  logic [ADDR_WD-1:0] i_addr,
   output logic               i_rvalid,
   output logic [DATA_WD-1:0] i_rdata,
   output logic               i_rlast,
   // DCache refill / write-back side
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_WD-1:0] d_addr,
   input  logic [DATA_WD-1:0] d_wdata,
   output logic               d_wready,
   output logic               d_rvalid,
   output logic [DATA_WD-1:0] d_rdata,
   output logic               d_done,
   // memory bus side
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_WD-1:0] mem_addr,
   input  logic               mem_ready,
   output logic               mem_wvalid,
   output logic [DATA_WD-1:0] mem_wdata,
   output logic               mem_wlast,
   input  logic               mem_wready,
   input  logic               mem_rvalid,
   input  logic [DATA_WD-1:0] mem_rdata,
   input  logic               mem_bvalid,
   output logic               busy
);

   localparam int unsigned       CNT_WD     = $clog2(BURST_LEN);
   localparam int unsigned       LINE_BYTES = BURST_LEN * DATA_WD / 8;
   localparam logic [ADDR_WD-1:0] LINE_MASK = ~(ADDR_WD'(LINE_BYTES) - ADDR_WD'(1));
   localparam logic [CNT_WD-1:0]  LAST_BEAT = CNT_WD'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_RDATA,
      S_WDATA,
      S_WRESP
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_WD-1:0]  r_cnt, w_cnt_nxt;
   logic               r_own_d, w_own_d_nxt;
   logic               r_rr_last_d, w_rr_last_d_nxt;
   logic               r_we, w_we_nxt;
   logic [ADDR_WD-1:0] r_addr, w_addr_nxt;
   logic               w_grant_d;
   logic               w_last;

   // State, beat counter and latched transaction attributes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_own_d     <= 1'b0;
         r_rr_last_d <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_own_d     <= w_own_d_nxt;
         r_rr_last_d <= w_rr_last_d_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
      end
   end

   // Arbitration, burst sequencing and output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_own_d_nxt     = r_own_d;
      w_rr_last_d_nxt = r_rr_last_d;
      w_we_nxt        = r_we;
      w_addr_nxt      = r_addr;
      i_rvalid        = 1'b0;
      i_rdata         = '0;
      i_rlast         = 1'b0;
      d_wready        = 1'b0;
      d_rvalid        = 1'b0;
      d_rdata         = '0;
      d_done          = 1'b0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wvalid      = 1'b0;
      mem_wdata       = '0;
      mem_wlast       = 1'b0;
      busy            = (r_state != S_IDLE);

      // D wins a tie only if it did not own the previous transaction
      w_grant_d = d_req & (~i_req | ~r_rr_last_d);
      w_last    = (r_cnt == LAST_BEAT);

      case (r_state)
         S_IDLE: begin
            if (i_req | d_req) begin
               w_own_d_nxt     = w_grant_d;
               w_rr_last_d_nxt = w_grant_d;
               w_addr_nxt      = w_grant_d ? d_addr : i_addr;
               w_we_nxt        = w_grant_d & d_we;
               w_state_nxt     = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_req  = 1'b1;
            mem_we   = r_we;
            mem_addr = r_addr & LINE_MASK;
            if (mem_ready) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_we ? S_WDATA : S_RDATA;
            end
         end
         S_RDATA: begin
            if (r_own_d) begin
               d_rvalid = mem_rvalid;
               d_rdata  = mem_rdata;
            end else begin
               i_rvalid = mem_rvalid;
               i_rdata  = mem_rdata;
            end
            if (mem_rvalid) begin
               w_cnt_nxt = r_cnt + CNT_WD'(1);
               if (w_last) begin
                  d_done      = r_own_d;
                  i_rlast     = ~r_own_d;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_WDATA: begin
            mem_wvalid = 1'b1;
            mem_wdata  = d_wdata;
            mem_wlast  = w_last;
            d_wready   = mem_wready;
            if (mem_wready) begin
               w_cnt_nxt = r_cnt + CNT_WD'(1);
               if (w_last) begin
                  w_state_nxt = S_WRESP;
               end
            end
         end
         S_WRESP: begin
            if (mem_bvalid) begin
               d_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios, a transaction-level model
// checked every cycle, and literal expectations per scenario.
module tb_cache_mem_arbiter;

   localparam int unsigned LINE = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr;
   logic [63:0] d_wdata, mem_rdata;
   logic        mem_ready, mem_wready, mem_rvalid, mem_bvalid;
   logic        i_rvalid, i_rlast, d_wready, d_rvalid, d_done;
   logic [63:0] i_rdata, d_rdata, mem_wdata;
   logic        mem_req, mem_we, mem_wvalid, mem_wlast, busy;
   logic [31:0] mem_addr;

   cache_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast), .mem_wready(mem_wready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 address, 2 read beats, 3 write beats, 4 response
   int          m_ph = 0;
   int          m_left = 0;
   bit          m_on = 1'b0;
   bit          m_own_d = 1'b0;
   bit          m_pref_d = 1'b1;
   bit          m_we = 1'b0;
   logic [31:0] m_line = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_on = 1'b1; m_ph = 0; m_left = 0; m_own_d = 1'b0; m_pref_d = 1'b1; m_we = 1'b0; m_line = '0;
      end else begin
         case (m_ph)
            0: if (i_req || d_req) begin
                  m_own_d  = d_req && (!i_req || m_pref_d);
                  m_pref_d = !m_own_d;
                  m_we     = m_own_d && d_we;
                  m_line   = m_own_d ? d_addr : i_addr;
                  m_line   = m_line - (m_line % LINE);
                  m_ph     = 1;
               end
            1: if (mem_ready) begin m_ph = m_we ? 3 : 2; m_left = 4; end
            2: if (mem_rvalid) begin m_left--; if (m_left == 0) m_ph = 0; end
            3: if (mem_wready) begin m_left--; if (m_left == 0) m_ph = 4; end
            4: if (mem_bvalid) m_ph = 0;
            default: m_ph = 0;
         endcase
      end
   end

   // Scenario event counters (observed DUT activity)
   int          cnt_irv, cnt_drv, cnt_rlast, cnt_done, cnt_wready, cnt_wlast, cnt_req, cnt_busy;
   logic [63:0] last_irdata;
   logic [31:0] last_req_addr;

   task automatic clr_cnt();
      cnt_irv = 0; cnt_drv = 0; cnt_rlast = 0; cnt_done = 0;
      cnt_wready = 0; cnt_wlast = 0; cnt_req = 0; cnt_busy = 0;
      last_irdata = '0; last_req_addr = '0;
   endtask

   // Cycle compare against the model, plus event counting
   always @(negedge clk) begin
      if (m_on) begin
         bit e_rd, e_wr, e_last, e_irv, e_drv;
         e_rd   = (m_ph == 2);
         e_wr   = (m_ph == 3);
         e_last = (m_left == 1);
         e_irv  = e_rd && !m_own_d && mem_rvalid;
         e_drv  = e_rd && m_own_d && mem_rvalid;
         chk("busy", 64'(busy), 64'(m_ph != 0));
         chk("mem_req", 64'(mem_req), 64'(m_ph == 1));
         chk("mem_we", 64'(mem_we), 64'(m_ph == 1 && m_we));
         chk("mem_addr", 64'(mem_addr), (m_ph == 1) ? 64'(m_line) : 64'd0);
         chk("i_rvalid", 64'(i_rvalid), 64'(e_irv));
         chk("d_rvalid", 64'(d_rvalid), 64'(e_drv));
         chk("i_rlast", 64'(i_rlast), 64'(e_irv && e_last));
         chk("d_done", 64'(d_done), 64'((e_drv && e_last) || (m_ph == 4 && mem_bvalid)));
         chk("mem_wvalid", 64'(mem_wvalid), 64'(e_wr));
         chk("mem_wlast", 64'(mem_wlast), 64'(e_wr && e_last));
         chk("d_wready", 64'(d_wready), 64'(e_wr && mem_wready));
         if (e_irv) chk("i_rdata", i_rdata, mem_rdata);
         else if (m_ph == 0) chk("i_rdata_idle", i_rdata, 64'd0);
         if (e_drv) chk("d_rdata", d_rdata, mem_rdata);
         else if (m_ph == 0) chk("d_rdata_idle", d_rdata, 64'd0);
         if (e_wr) chk("mem_wdata", mem_wdata, d_wdata);
         else if (m_ph == 0) chk("mem_wdata_idle", mem_wdata, 64'd0);

         if (i_rvalid) begin cnt_irv++; last_irdata = i_rdata; end
         if (d_rvalid) cnt_drv++;
         if (i_rlast) cnt_rlast++;
         if (d_done) cnt_done++;
         if (d_wready) cnt_wready++;
         if (mem_wlast && mem_wready) cnt_wlast++;
         if (mem_req) begin cnt_req++; last_req_addr = mem_addr; end
         if (busy) cnt_busy++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   bit wr_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   // Memory-side responder for one transaction; returns whether DCache was served
   task automatic serve(input int rdy_dly, input int bdly, input logic [63:0] base, output bit got_d);
      int t;
      bit last;
      got_d = 1'b0;
      t = 0;
      while (mem_req !== 1'b1 && t < 20) begin tick(); t++; end
      chk("grant_seen", 64'(mem_req), 64'd1);
      if (mem_req !== 1'b1) return;
      // requester-side changes after grant must not leak into the burst
      i_addr = ~i_addr;
      d_addr = ~d_addr;
      repeat (rdy_dly) tick();
      mem_ready = 1'b1;
      if (mem_we) begin
         got_d = 1'b1;
         tick();
         mem_ready = 1'b0;
         last = 1'b0;
         for (int k = 0; k < 40 && !last; k++) begin
            mem_wready = wr_pat[k % 6];
            d_wdata    = 64'hD0 + 64'(k);
            #1;
            last = mem_wready && mem_wlast;
            tick();
         end
         mem_wready = 1'b0;
         repeat (bdly) tick();
         mem_bvalid = 1'b1;
         tick();
         mem_bvalid = 1'b0;
      end else begin
         tick();
         mem_ready = 1'b0;
         for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 64'(b);
            #1;
            if (b == 0) got_d = d_rvalid;
            tick();
         end
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit g1, g2, g3;
      int t;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      mem_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
      clr_cnt();
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_mem_req", 64'(mem_req), 64'd0);

      // lone ICache refill
      clr_cnt();
      i_addr = 32'h8000_0014; i_req = 1'b1;
      serve(1, 0, 64'hA0, g1);
      i_req = 1'b0;
      chk("s1_owner_d", 64'(g1), 64'd0);
      chk("s1_addr", 64'(last_req_addr), 64'h8000_0000);
      chk("s1_req_cycles", 64'(cnt_req), 64'd2);
      chk("s1_i_beats", 64'(cnt_irv), 64'd4);
      chk("s1_d_beats", 64'(cnt_drv), 64'd0);
      chk("s1_rlast", 64'(cnt_rlast), 64'd1);
      chk("s1_last_data", last_irdata, 64'hA3);

      // contention: D, then I, then D again
      clr_cnt();
      i_addr = 32'h1000_0040; d_addr = 32'h2000_0088; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      serve(0, 0, 64'hB0, g1);
      d_req = 1'b0;
      serve(0, 0, 64'hC0, g2);
      i_req = 1'b1; d_req = 1'b1;
      serve(0, 0, 64'hB8, g3);
      i_req = 1'b0; d_req = 1'b0;
      chk("s2_first_d", 64'(g1), 64'd1);
      chk("s2_second_i", 64'(g2), 64'd0);
      chk("s2_third_d", 64'(g3), 64'd1);
      chk("s2_d_beats", 64'(cnt_drv), 64'd8);
      chk("s2_i_beats", 64'(cnt_irv), 64'd4);

      // DCache write-back with stalled write beats and a slow response
      tick();
      clr_cnt();
      d_addr = 32'h0000_1238; d_we = 1'b1; d_req = 1'b1;
      serve(0, 2, 64'h0, g1);
      d_req = 1'b0; d_we = 1'b0;
      chk("s3_owner_d", 64'(g1), 64'd1);
      chk("s3_wready", 64'(cnt_wready), 64'd4);
      chk("s3_wlast", 64'(cnt_wlast), 64'd1);
      chk("s3_done", 64'(cnt_done), 64'd1);
      chk("s3_busy_cycles", 64'(cnt_busy), 64'd10);
      chk("s3_addr", 64'(last_req_addr), 64'h0000_1220);

      // slow address acceptance
      tick();
      clr_cnt();
      d_addr = 32'h4000_0020; d_req = 1'b1;
      serve(5, 0, 64'hE0, g1);
      d_req = 1'b0;
      chk("s4_req_cycles", 64'(cnt_req), 64'd6);
      chk("s4_addr", 64'(last_req_addr), 64'h4000_0020);
      chk("s4_d_beats", 64'(cnt_drv), 64'd4);
      chk("s4_done", 64'(cnt_done), 64'd1);

      // reset during the second beat of an ICache refill
      tick();
      clr_cnt();
      i_addr = 32'h0000_0100; i_req = 1'b1;
      t = 0;
      while (mem_req !== 1'b1 && t < 20) begin tick(); t++; end
      chk("s5_grant", 64'(mem_req), 64'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 64'hF0;
      tick();
      mem_rdata = 64'hF1; reset = 1'b1;
      tick();
      reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; i_req = 1'b0;
      chk("s5_busy", 64'(busy), 64'd0);
      chk("s5_irv", 64'(i_rvalid), 64'd0);
      chk("s5_i_beats", 64'(cnt_irv), 64'd2);
      chk("s5_rlast", 64'(cnt_rlast), 64'd0);
      chk("s5_done", 64'(cnt_done), 64'd0);
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
      serve(0, 0, 64'h70, g1);
      i_req = 1'b0; d_req = 1'b0;
      chk("s5_fresh_d", 64'(g1), 64'd1);

      // stray read beats and write responses while idle
      tick();
      clr_cnt();
      mem_rvalid = 1'b1; mem_bvalid = 1'b1; mem_rdata = 64'h123;
      repeat (3) tick();
      mem_rvalid = 1'b0; mem_bvalid = 1'b0; mem_rdata = '0;
      tick();
      chk("s6_busy", 64'(cnt_busy), 64'd0);
      chk("s6_beats", 64'(cnt_irv + cnt_drv), 64'd0);
      chk("s6_done", 64'(cnt_done), 64'd0);

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
